// File: rtl/halt_mem_dumper_if.sv
// SRAM read port and element stream of halt_mem_dumper.
// master = dumper side, slave = SRAM/consumer side.
interface halt_mem_dumper_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64
) ();
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              dump_valid;
    logic              dump_ready;
    logic [15:0]       dump_index;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;

    modport master (
        output mem_rd_en, mem_addr,
        input  mem_rdata,
        output dump_valid, dump_index, dump_addr, dump_data,
        input  dump_ready
    );

    modport slave (
        input  mem_rd_en, mem_addr,
        output mem_rdata,
        input  dump_valid, dump_index, dump_addr, dump_data,
        output dump_ready
    );
endinterface

// File: rtl/halt_mem_dumper.sv
// On halt, reads COUNT elements of DATA_W bits from the data SRAM and streams them out.
// Optional console FIFO for print events is built when HALT_DUMPER_CONSOLE_EN is defined.
module halt_mem_dumper #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 64,
    parameter int BASE_ADDR = 0,
    parameter int COUNT     = 9,
    parameter int STRIDE    = 8,
    parameter int CON_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    halt_mem_dumper_if.master bus,
    output logic              busy,
    output logic              done,
    input  logic              print_flag,
    input  logic [7:0]        print_char,
    output logic              char_valid,
    output logic [7:0]        char_data,
    input  logic              char_ready,
    output logic              con_overflow
);
    localparam int                BEATS     = DATA_W / 32;
    localparam int                BEAT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [15:0]       LAST_IDX  = 16'((COUNT > 0) ? COUNT - 1 : 0);

    typedef enum logic [2:0] {IDLE, RD, CAP, OUT, DONE} state_t;

    state_t            state, state_nxt;
    logic [15:0]       idx;
    logic [BEAT_W-1:0] beat;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] elem_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              last_beat;
    logic              last_elem;

    // Address arithmetic is done in 32 bits and truncated, so wrap-around is free.
    assign elem_addr = ADDR_W'(BASE_ADDR + int'(idx) * STRIDE);
    assign rd_addr   = elem_addr + ADDR_W'(int'(beat) * 4);
    assign last_beat = (beat == LAST_BEAT);
    assign last_elem = (idx == LAST_IDX);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (halt) state_nxt = (COUNT == 0) ? DONE : RD;
            RD:      state_nxt = CAP;
            CAP:     state_nxt = last_beat ? OUT : RD;
            OUT:     if (bus.dump_ready) state_nxt = last_elem ? DONE : RD;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            beat   <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE: if (halt) begin
                    idx  <= '0;
                    beat <= '0;
                end
                CAP: begin
                    // Beat b lands in bits [32b +: 32]: lowest address in lowest bits.
                    for (int b = 0; b < BEATS; b++)
                        if (beat == BEAT_W'(b)) data_q[32*b +: 32] <= bus.mem_rdata;
                    if (!last_beat) beat <= beat + 1'b1;
                end
                OUT: if (bus.dump_ready && !last_elem) begin
                    idx  <= idx + 16'd1;
                    beat <= '0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.mem_rd_en  = 1'b0;
        bus.mem_addr   = '0;
        bus.dump_valid = 1'b0;
        bus.dump_index = '0;
        bus.dump_addr  = '0;
        bus.dump_data  = '0;
        busy           = 1'b0;
        done           = 1'b0;
        case (state)
            RD: begin
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = {rd_addr[ADDR_W-1:2], 2'b00};
                busy          = 1'b1;
            end
            CAP: busy = 1'b1;
            OUT: begin
                busy           = 1'b1;
                bus.dump_valid = 1'b1;
                bus.dump_index = idx;
                bus.dump_addr  = elem_addr;
                bus.dump_data  = data_q;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

`ifdef HALT_DUMPER_CONSOLE_EN
    localparam int PTR_W = $clog2(CON_DEPTH);

    logic [7:0]       fifo_mem [CON_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fill;
    logic             flag_q, push, pop, full, accept;

    // print_flag is toggle-signalled: either edge is one event.
    assign push       = print_flag ^ flag_q;
    assign pop        = char_valid & char_ready;
    assign full       = (fill == (PTR_W + 1)'(CON_DEPTH));
    assign accept     = push & (~full | pop);
    assign char_valid = (fill != '0);
    assign char_data  = char_valid ? fifo_mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q       <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fill         <= '0;
            con_overflow <= 1'b0;
        end else begin
            flag_q <= print_flag;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (accept && !pop)      fill <= fill + 1'b1;
            else if (pop && !accept) fill <= fill - 1'b1;
            if (push && !accept) con_overflow <= 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; fill gates char_data, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr] <= print_char;
    end
`else
    logic con_unused;

    assign char_valid   = 1'b0;
    assign char_data    = 8'h00;
    assign con_overflow = 1'b0;
    assign con_unused   = ^{print_flag, print_char, char_ready, 32'(CON_DEPTH)};
`endif

endmodule

// File: tb/tb_halt_mem_dumper.sv
// Directed bench for halt_mem_dumper: default dump, stall, mid-dump reset,
// COUNT=0, address wrap with DATA_W=32, and the console FIFO.
module tb_halt_mem_dumper;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, halt, halt_z, halt_w;
    logic       busy, done, busy_z, done_z, busy_w, done_w;
    logic       print_flag, char_ready, char_valid, con_overflow;
    logic [7:0] print_char, char_data;
    logic       cv_z, co_z, cv_w, co_w;
    logic [7:0] cd_z, cd_w;
    logic [31:0] sram [0:31];
    int n_checks = 0;
    int n_errors = 0;
    int lat;

    halt_mem_dumper_if #(.ADDR_W(16), .DATA_W(64)) bus_d ();
    halt_mem_dumper_if #(.ADDR_W(16), .DATA_W(64)) bus_z ();
    halt_mem_dumper_if #(.ADDR_W(16), .DATA_W(32)) bus_w ();

    halt_mem_dumper u_dut (
        .clk(clk), .rst(rst), .halt(halt), .bus(bus_d), .busy(busy), .done(done),
        .print_flag(print_flag), .print_char(print_char), .char_valid(char_valid),
        .char_data(char_data), .char_ready(char_ready), .con_overflow(con_overflow)
    );

    halt_mem_dumper #(.COUNT(0)) u_zero (
        .clk(clk), .rst(rst), .halt(halt_z), .bus(bus_z), .busy(busy_z), .done(done_z),
        .print_flag(1'b0), .print_char(8'h00), .char_valid(cv_z),
        .char_data(cd_z), .char_ready(1'b0), .con_overflow(co_z)
    );

    halt_mem_dumper #(.DATA_W(32), .BASE_ADDR(16'hFFF8), .COUNT(2), .STRIDE(8)) u_wrap (
        .clk(clk), .rst(rst), .halt(halt_w), .bus(bus_w), .busy(busy_w), .done(done_w),
        .print_flag(1'b0), .print_char(8'h00), .char_valid(cv_w),
        .char_data(cd_w), .char_ready(1'b0), .con_overflow(co_w)
    );

    // SRAM models: one-cycle read latency.
    always @(posedge clk) begin
        if (bus_d.mem_rd_en) bus_d.mem_rdata <= sram[bus_d.mem_addr[6:2]];
        if (bus_w.mem_rd_en) bus_w.mem_rdata <= {16'hA5A5, bus_w.mem_addr};
    end
    assign bus_z.mem_rdata = 32'h0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until dump_valid, bounded; an expired bound shows up as a wrong latency.
    task automatic wait_valid(output int n);
        n = 0;
        while (!bus_d.dump_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [63:0] exp_data(input int e);
        return (e == 2) ? 64'hFFFF_FFFF_FFFF_FFFB : 64'(e + 1);
    endfunction

    initial begin
        rst = 1'b1; halt = 1'b0; halt_z = 1'b0; halt_w = 1'b0;
        print_flag = 1'b0; print_char = 8'h00; char_ready = 1'b0;
        bus_d.dump_ready = 1'b1; bus_z.dump_ready = 1'b1; bus_w.dump_ready = 1'b1;
        for (int i = 0; i < 32; i++) sram[i] = (i % 2 == 0 && i < 18) ? 32'(i / 2 + 1) : 32'h0;
        sram[4] = 32'hFFFF_FFFB;
        sram[5] = 32'hFFFF_FFFF;

        tick(); tick();
        check("rst_valid", bus_d.dump_valid, 0);
        check("rst_rd_en", bus_d.mem_rd_en, 0);
        check("rst_addr", bus_d.mem_addr, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", bus_d.dump_data, 0);
        check("rst_index", bus_d.dump_index, 0);
        check("rst_char_valid", char_valid, 0);
        check("rst_overflow", con_overflow, 0);
        rst = 1'b0;
        tick();

        // COUNT=0: straight to DONE without any SRAM access.
        halt_z = 1'b1;
        check("zero_done_before", done_z, 0);
        tick();
        halt_z = 1'b0;
        check("zero_done", done_z, 1);
        check("zero_rd_en", bus_z.mem_rd_en, 0);
        check("zero_busy", busy_z, 0);

        // Wrap case: 0xFFF8 then 0x0000, one beat per element.
        halt_w = 1'b1;
        tick();
        halt_w = 1'b0;
        check("wrap_rd_en0", bus_w.mem_rd_en, 1);
        check("wrap_rd_addr0", bus_w.mem_addr, 16'hFFF8);
        tick(); tick();
        check("wrap_valid0", bus_w.dump_valid, 1);
        check("wrap_addr0", bus_w.dump_addr, 16'hFFF8);
        check("wrap_data0", bus_w.dump_data, 32'hA5A5_FFF8);
        tick();
        check("wrap_rd_addr1", bus_w.mem_addr, 16'h0000);
        check("wrap_rd_en1", bus_w.mem_rd_en, 1);
        tick(); tick();
        check("wrap_index1", bus_w.dump_index, 1);
        check("wrap_addr1", bus_w.dump_addr, 16'h0000);
        check("wrap_data1", bus_w.dump_data, 32'hA5A5_0000);
        tick();
        check("wrap_done", done_w, 1);

        // Default dump of nine doublewords, with a 10-cycle stall on element 3.
        halt = 1'b1;
        tick();
        halt = 1'b0;
        for (int e = 0; e < 9; e++) begin
            check($sformatf("rd_en_e%0d", e), bus_d.mem_rd_en, 1);
            check($sformatf("rd_addr_e%0d", e), bus_d.mem_addr, 8 * e);
            wait_valid(lat);
            check($sformatf("latency_e%0d", e), lat, 4);
            check($sformatf("index_e%0d", e), bus_d.dump_index, e);
            check($sformatf("addr_e%0d", e), bus_d.dump_addr, 8 * e);
            check($sformatf("data_e%0d", e), bus_d.dump_data, exp_data(e));
            if (e == 3) begin
                bus_d.dump_ready = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    tick();
                    check("stall_valid", bus_d.dump_valid, 1);
                    check("stall_data", bus_d.dump_data, exp_data(3));
                    check("stall_index", bus_d.dump_index, 3);
                    check("stall_addr", bus_d.dump_addr, 24);
                    check("stall_rd_en", bus_d.mem_rd_en, 0);
                end
                bus_d.dump_ready = 1'b1;
            end
            tick();
            if (e < 8) check($sformatf("valid_drop_e%0d", e), bus_d.dump_valid, 0);
        end
        check("done_after_dump", done, 1);
        check("busy_after_dump", busy, 0);
        check("valid_after_dump", bus_d.dump_valid, 0);
        check("rd_en_after_dump", bus_d.mem_rd_en, 0);
        halt = 1'b1;
        tick(); tick();
        halt = 1'b0;
        check("done_ignores_halt", done, 1);
        check("rd_en_ignores_halt", bus_d.mem_rd_en, 0);

        // Reset during CAP of element 5, then restart.
        rst = 1'b1;
        #1;
        check("rst_from_done", done, 0);
        tick();
        rst = 1'b0;
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        for (int e = 0; e < 5; e++) begin
            wait_valid(lat);
            tick();
        end
        check("e5_rd_addr", bus_d.mem_addr, 40);
        tick();
        check("e5_cap_busy", busy, 1);
        check("e5_cap_rd_en", bus_d.mem_rd_en, 0);
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", bus_d.dump_valid, 0);
        check("abort_rd_en", bus_d.mem_rd_en, 0);
        check("abort_index", bus_d.dump_index, 0);
        check("abort_data", bus_d.dump_data, 0);
        check("abort_done", done, 0);
        tick();
        rst = 1'b0;
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("restart_rd_en", bus_d.mem_rd_en, 1);
        check("restart_rd_addr", bus_d.mem_addr, 0);
        wait_valid(lat);
        check("restart_latency", lat, 4);
        check("restart_index", bus_d.dump_index, 0);
        check("restart_addr", bus_d.dump_addr, 0);
        check("restart_data", bus_d.dump_data, 64'd1);

        // Console: five toggles carrying 'a'..'e' with the consumer stalled.
        char_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            print_char = 8'(8'h61 + k);
            print_flag = ~print_flag;
            tick();
`ifdef HALT_DUMPER_CONSOLE_EN
            if (k == 0) begin
                check("con_first_valid", char_valid, 1);
                check("con_first_data", char_data, 8'h61);
            end
`endif
        end
`ifdef HALT_DUMPER_CONSOLE_EN
        check("con_overflow", con_overflow, 1);
        char_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("con_valid_%0d", k), char_valid, 1);
            check($sformatf("con_data_%0d", k), char_data, 8'(8'h61 + k));
            tick();
        end
        check("con_empty", char_valid, 0);
        check("con_overflow_sticky", con_overflow, 1);
        char_ready = 1'b0;
`else
        check("con_off_valid", char_valid, 0);
        check("con_off_data", char_data, 0);
        check("con_off_overflow", con_overflow, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
